lc3_decode_stage: RTL

LC-3 decode pipeline stage: the RTL block that consumes the `decode_in` interface (enable_decode, dout, npc_in). It sits between fetch and execute. On each enabled cycle it registers the fetched instruction and next-PC, and produces the execute, writeback and memory control words for the downstream stages. It also produces a valid strobe, an illegal-opcode flag and a wrapping accepted-instruction count for the `decode_out` monitor.

---
 rtl/lc3_decode_stage.sv | 77 +++++++
 1 files changed

// File: rtl/lc3_decode_stage.sv
// lc3_decode_stage: LC-3 decode stage that registers the instruction and next PC and produces the execute, writeback and memory control words
module lc3_decode_stage #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable_decode,
  input  logic [15:0]      dout,
  input  logic [15:0]      npc_in,
  output logic [15:0]      IR,
  output logic [15:0]      npc_out,
  output logic [5:0]       E_Control,
  output logic [1:0]       W_Control,
  output logic             Mem_Control,
  output logic             decode_valid,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);
  logic [3:0] op;
  logic is_add, is_and, is_not, off9, off6, is_jmp, ill;
  logic [1:0] alu, pcsel1, wsel;
  logic [15:0] ir_d, ir_q, npc_d, npc_q;
  logic [5:0] e_d, e_q;
  logic [1:0] w_d, w_q;
  logic mem_d, mem_q, valid_d, valid_q, ill_d, ill_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  assign op     = dout[15:12];
  assign is_add = op == 4'b0001;
  assign is_and = op == 4'b0101;
  assign is_not = op == 4'b1001;
  assign off9   = op inside {4'b0000, 4'b0010, 4'b1010, 4'b1110, 4'b0011, 4'b1011};
  assign off6   = op inside {4'b0110, 4'b0111};
  assign is_jmp = op == 4'b1100;
  assign ill    = op inside {4'b0100, 4'b1000, 4'b1101, 4'b1111};
  assign alu    = is_and ? 2'b01 : is_not ? 2'b10 : 2'b00;
  assign pcsel1 = off9 ? 2'b01 : off6 ? 2'b10 : is_jmp ? 2'b11 : 2'b00;
  assign wsel   = (op inside {4'b0010, 4'b0110, 4'b1010}) ? 2'b01 : op == 4'b1110 ? 2'b10 : 2'b00;
  always_comb begin
    ir_d    = enable_decode ? dout : ir_q;
    npc_d   = enable_decode ? npc_in : npc_q;
    e_d     = enable_decode ? {alu, pcsel1, off9, (is_add | is_and) & dout[5]} : e_q;
    w_d     = enable_decode ? wsel : w_q;
    mem_d   = enable_decode ? (op == 4'b1010 || op == 4'b1011) : mem_q;
    ill_d   = enable_decode ? ill : ill_q;
    cnt_d   = enable_decode ? cnt_q + 1'b1 : cnt_q;
    valid_d = enable_decode;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      ir_q    <= '0;
      npc_q   <= '0;
      e_q     <= '0;
      w_q     <= '0;
      mem_q   <= 1'b0;
      valid_q <= 1'b0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      ir_q    <= ir_d;
      npc_q   <= npc_d;
      e_q     <= e_d;
      w_q     <= w_d;
      mem_q   <= mem_d;
      valid_q <= valid_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
    end
  end
  assign IR           = ir_q;
  assign npc_out      = npc_q;
  assign E_Control    = e_q;
  assign W_Control    = w_q;
  assign Mem_Control  = mem_q;
  assign decode_valid = valid_q;
  assign illegal_op   = ill_q;
  assign instr_count  = cnt_q;
endmodule
